// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between icache and dcache.
// Ports: CLK/RST, icache (iREN,iaddr,iwait,iload), dcache (dREN,dWEN,daddr,
// dstore,dwait,dload), RAM (ramREN,ramWEN,ramaddr,ramstore,ramload,
// ramstate), debug grant, sticky mem_err.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic [1:0]  grant,
  output logic        mem_err
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2
  } state_t;

  state_t state, nextState;
  logic [CW-1:0] starveCnt, nextCnt;

  logic dReq, ramDone, starved;
  logic iDone, dDone;

  assign dReq    = dREN | dWEN;
  // ACCESS and ERROR both end an access
  assign ramDone = ramstate[1];
  assign starved = iREN && (starveCnt == LIMIT);

  // completion requires the requester still asking;
  // a dropped request is an abort, not a completion
  assign dDone = (state == DSERV) && dReq && ramDone;
  assign iDone = (state == ISERV) && iREN && ramDone;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      starveCnt <= '0;
      mem_err   <= 1'b0;
    end else begin
      state     <= nextState;
      starveCnt <= nextCnt;
      if ((iDone || dDone) && ramstate == RAM_ERROR)
        mem_err <= 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (starved)   nextState = ISERV;
        else if (dReq) nextState = DSERV;
        else if (iREN) nextState = ISERV;
        else           nextState = IDLE;
      end
      DSERV: begin
        if (!dReq || dDone) nextState = IDLE;
      end
      ISERV: begin
        if (!iREN || iDone) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    nextCnt = starveCnt;
    if (state == IDLE) begin
      if (!iREN)
        nextCnt = '0;
      else if (nextState == ISERV)
        nextCnt = '0;
      else if (nextState == DSERV && starveCnt != LIMIT)
        nextCnt = starveCnt + CW'(1);
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    grant    = 2'b00;
    iload    = '0;
    dload    = '0;
    iwait    = iREN & ~iDone;
    dwait    = dReq & ~dDone;
    unique case (state)
      DSERV: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        grant    = 2'b10;
        if (dDone && ramstate == RAM_ACCESS)
          dload = ramload;
      end
      ISERV: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        grant   = 2'b01;
        if (iDone && ramstate == RAM_ACCESS)
          iload = ramload;
      end
      default: ;
    endcase
  end

endmodule
